// File: rtl/lsm_sequencer_pkg.sv
// Shared definitions for the load/store-multiple sequencer: sizes, state
// encoding and the mask-bit to register-index mapping.
package lsm_sequencer_pkg;

    localparam int NREG = 8;
    localparam int RA_W = 3;
    localparam int AW   = 16;

    localparam logic [NREG-1:0] MASK_ONE = {{(NREG-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]   ADDR_INC = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Mask bit [NREG-1] is R0, bit [0] is R(NREG-1)
    function automatic logic [RA_W-1:0] bit_to_reg(input logic [RA_W-1:0] bit_pos);
        return RA_W'(NREG - 1) - bit_pos;
    endfunction

endpackage

// File: rtl/lsm_sequencer_if.sv
// Handshake bundle between decode/execute, the sequencer and the memory stage.
interface lsm_sequencer_if;
    import lsm_sequencer_pkg::*;

    logic            start;
    logic            is_load;
    logic [NREG-1:0] reg_list;
    logic [AW-1:0]   base_addr;
    logic            mem_ready;
    logic            busy;
    logic            stall_req;
    logic [RA_W-1:0] reg_addr;
    logic [NREG-1:0] reg_sel;
    logic            reg_we;
    logic [AW-1:0]   mem_addr;
    logic            mem_rd;
    logic            mem_wr;
    logic            done;

    modport master (
        output start, is_load, reg_list, base_addr, mem_ready,
        input  busy, stall_req, reg_addr, reg_sel, reg_we,
               mem_addr, mem_rd, mem_wr, done
    );

    modport slave (
        input  start, is_load, reg_list, base_addr, mem_ready,
        output busy, stall_req, reg_addr, reg_sel, reg_we,
               mem_addr, mem_rd, mem_wr, done
    );

endinterface

// File: rtl/lsm_sequencer_pick.sv
// Fixed-order register picker: selects the highest set mask bit (lowest
// register number) and returns the mask with that bit cleared.
module lsm_pick
    import lsm_sequencer_pkg::*;
(
    input  logic [NREG-1:0] i_mask,
    output logic [RA_W-1:0] o_idx,
    output logic            o_valid,
    output logic [NREG-1:0] o_next_mask
);

    logic [RA_W-1:0] w_bit;

    // Scan upward so the highest set bit is the one left standing
    always_comb begin
        w_bit = {RA_W{1'b0}};
        for (int i = 0; i < NREG; i++) begin
            w_bit = i_mask[i] ? RA_W'(i) : w_bit;
        end
    end

    assign o_valid     = |i_mask;
    assign o_idx       = bit_to_reg(w_bit);
    assign o_next_mask = i_mask & ~(MASK_ONE << w_bit);

endmodule

// File: rtl/lsm_sequencer.sv
// Load/store-multiple sequencer: walks a latched register mask one transfer
// per accepted memory cycle and stalls upstream until the list is exhausted.
module lsm_sequencer
    import lsm_sequencer_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    lsm_sequencer_if.slave bus
);

    state_e          r_state;
    state_e          w_state_next;
    logic [NREG-1:0] r_mask;
    logic [AW-1:0]   r_addr;
    logic            r_is_load;

    logic [RA_W-1:0] w_idx;
    logic            w_valid;
    logic [NREG-1:0] w_next_mask;
    logic            w_run;

    lsm_pick u_pick (
        .i_mask      (r_mask),
        .o_idx       (w_idx),
        .o_valid     (w_valid),
        .o_next_mask (w_next_mask)
    );

    assign w_run = (r_state == ST_RUN);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; an empty mask in RUN is treated as finished
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_next = (bus.reg_list != {NREG{1'b0}}) ? ST_RUN : ST_DONE;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!w_valid) begin
                    w_state_next = ST_DONE;
                end else if (bus.mem_ready && (w_next_mask == {NREG{1'b0}})) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Mask, address and mode registers; inputs are sampled only in IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask    <= {NREG{1'b0}};
            r_addr    <= {AW{1'b0}};
            r_is_load <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_mask    <= bus.reg_list;
                        r_addr    <= bus.base_addr;
                        r_is_load <= bus.is_load;
                    end
                end
                ST_RUN: begin
                    if (bus.mem_ready) begin
                        r_mask <= w_next_mask;
                        r_addr <= r_addr + ADDR_INC;
                    end
                end
                default: begin
                    r_mask <= r_mask;
                end
            endcase
        end
    end

    // Output decode; every strobe and index is forced low outside RUN
    always_comb begin
        bus.busy      = 1'b0;
        bus.stall_req = 1'b0;
        bus.reg_addr  = {RA_W{1'b0}};
        bus.reg_sel   = {NREG{1'b0}};
        bus.reg_we    = 1'b0;
        bus.mem_addr  = {AW{1'b0}};
        bus.mem_rd    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.done      = 1'b0;
        case (r_state)
            ST_RUN: begin
                bus.busy      = 1'b1;
                bus.stall_req = 1'b1;
                bus.reg_addr  = w_idx;
                bus.reg_sel   = MASK_ONE << w_idx;
                bus.reg_we    = r_is_load & bus.mem_ready;
                bus.mem_addr  = r_addr;
                bus.mem_rd    = r_is_load;
                bus.mem_wr    = ~r_is_load;
            end
            ST_DONE: begin
                bus.busy      = 1'b1;
                bus.stall_req = 1'b1;
                bus.done      = 1'b1;
            end
            default: begin
                bus.busy      = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_lsm_sequencer.sv
// Bench for lsm_sequencer: a fixed vector table, directed corner sequences
// and random traffic against a transfer-queue reference model.
module tb_lsm_sequencer;

    typedef struct packed {
        logic        busy;
        logic        stall;
        logic        done;
        logic [2:0]  raddr;
        logic [7:0]  sel;
        logic [15:0] maddr;
        logic        rd;
        logic        wr;
        logic        we;
    } outs_t;

    typedef struct packed {
        logic        rst;
        logic        st;
        logic        ld;
        logic [7:0]  lst;
        logic [15:0] bs;
        logic        rdy;
        outs_t       exp;
    } vec_t;

    typedef struct {
        logic [2:0]  r;
        logic [15:0] a;
    } xfer_t;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    int   we_seen = 0;

    xfer_t m_q[$];
    bit    m_done_pend = 1'b0;
    logic  m_load = 1'b0;

    lsm_sequencer_if bus();

    lsm_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic outs_t eo(input logic b, input logic d, input logic [2:0] ra,
                                 input logic [7:0] sl, input logic [15:0] ma,
                                 input logic rd, input logic wr, input logic we);
        outs_t o;
        o.busy = b; o.stall = b; o.done = d; o.raddr = ra; o.sel = sl;
        o.maddr = ma; o.rd = rd; o.wr = wr; o.we = we;
        return o;
    endfunction

    function automatic outs_t dut_outs();
        return eo(bus.busy, bus.done, bus.reg_addr, bus.reg_sel, bus.mem_addr,
                  bus.mem_rd, bus.mem_wr, bus.reg_we) | {bus.stall_req ^ bus.busy, 32'd0};
    endfunction

    // Expected outputs from the pending-transfer queue
    function automatic outs_t model_outs(input logic rdy);
        outs_t o = '0;
        if (m_q.size() > 0) begin
            o = eo(1'b1, 1'b0, m_q[0].r, 8'b1 << m_q[0].r, m_q[0].a,
                   m_load, !m_load, m_load & rdy);
        end else if (m_done_pend) begin
            o = eo(1'b1, 1'b1, 3'd0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        end
        return o;
    endfunction

    task automatic model_step(input logic rst, input logic st, input logic ld,
                              input logic [7:0] lst, input logic [15:0] bs, input logic rdy);
        int cnt;
        if (rst) begin
            m_q.delete();
            m_done_pend = 1'b0;
        end else if (m_q.size() > 0) begin
            if (rdy) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_done_pend = 1'b1;
            end
        end else if (m_done_pend) begin
            m_done_pend = 1'b0;
        end else if (st) begin
            m_load = ld;
            cnt = 0;
            for (int k = 0; k < 8; k++) begin
                if (lst[7-k]) begin
                    m_q.push_back('{r: 3'(k), a: bs + 16'(cnt)});
                    cnt++;
                end
            end
            if (m_q.size() == 0) m_done_pend = 1'b1;
        end
    endtask

    task automatic compare(input string name, input outs_t got, input outs_t exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic st, input logic ld,
                         input logic [7:0] lst, input logic [15:0] bs, input logic rdy);
        reset         = rst;
        bus.start     = st;
        bus.is_load   = ld;
        bus.reg_list  = lst;
        bus.base_addr = bs;
        bus.mem_ready = rdy;
    endtask

    task automatic cycle(input string name, input logic rst, input logic st, input logic ld,
                         input logic [7:0] lst, input logic [15:0] bs, input logic rdy);
        drive(rst, st, ld, lst, bs, rdy);
        #1;
        if (bus.reg_we === 1'b1) we_seen++;
        compare(name, dut_outs(), model_outs(rdy));
        model_step(rst, st, ld, lst, bs, rdy);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t  tbl[14];
        outs_t idle;
        idle = '0;

        tbl[0]  = '{1'b0, 1'b1, 1'b0, 8'hA1, 16'h0040, 1'b1, idle};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, eo(1'b1, 1'b0, 3'd0, 8'h01, 16'h0040, 1'b0, 1'b1, 1'b0)};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, eo(1'b1, 1'b0, 3'd2, 8'h04, 16'h0041, 1'b0, 1'b1, 1'b0)};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, eo(1'b1, 1'b0, 3'd7, 8'h80, 16'h0042, 1'b0, 1'b1, 1'b0)};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, eo(1'b1, 1'b1, 3'd0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0)};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 8'h00, 16'h5555, 1'b1, idle};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, eo(1'b1, 1'b1, 3'd0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0)};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 8'h04, 16'h1234, 1'b0, idle};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, eo(1'b1, 1'b0, 3'd5, 8'h20, 16'h1234, 1'b1, 1'b0, 1'b0)};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, eo(1'b1, 1'b0, 3'd5, 8'h20, 16'h1234, 1'b1, 1'b0, 1'b0)};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, eo(1'b1, 1'b0, 3'd5, 8'h20, 16'h1234, 1'b1, 1'b0, 1'b0)};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, eo(1'b1, 1'b0, 3'd5, 8'h20, 16'h1234, 1'b1, 1'b0, 1'b1)};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, eo(1'b1, 1'b1, 3'd0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0)};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, idle};

        drive(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
        @(posedge clk);
        #1;
        compare("reset_state", dut_outs(), idle);

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].rst, tbl[i].st, tbl[i].ld, tbl[i].lst, tbl[i].bs, tbl[i].rdy);
            #1;
            compare($sformatf("table_%0d", i), dut_outs(), tbl[i].exp);
            @(posedge clk);
            #1;
        end

        // LM of all eight registers with memory always ready
        we_seen = 0;
        cycle("lm_ff_start", 1'b0, 1'b1, 1'b1, 8'hFF, 16'h0100, 1'b1);
        for (int i = 0; i < 10; i++) cycle("lm_ff", 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
        n_vec++;
        if (we_seen != 8) begin
            n_err++;
            $display("FAIL lm_ff_we_count: got %0d expected 8", we_seen);
        end

        // Address wrap plus a start during RUN that must not re-latch
        cycle("wrap_start", 1'b0, 1'b1, 1'b0, 8'hC0, 16'hFFFF, 1'b1);
        cycle("wrap_restart", 1'b0, 1'b1, 1'b1, 8'hFF, 16'h0000, 1'b1);
        for (int i = 0; i < 3; i++) cycle("wrap", 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);

        // Reset in the second RUN cycle, then a fresh sequence
        cycle("rst_start", 1'b0, 1'b1, 1'b1, 8'hFF, 16'h0200, 1'b1);
        cycle("rst_run1", 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
        cycle("rst_run2", 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
        cycle("rst_after", 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
        cycle("fresh_start", 1'b0, 1'b1, 1'b0, 8'h81, 16'h0300, 1'b1);
        for (int i = 0; i < 4; i++) cycle("fresh", 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);

        for (int i = 0; i < 400; i++) begin
            cycle("random",
                  ($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255)),
                  16'($urandom_range(0, 65535)),
                  ($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lsm_sequencer.md
Name: lsm_sequencer

Overview:
- Multi-cycle sequencer for load-multiple (LM) and store-multiple (SM) instructions.
- Latches an 8-bit register list and walks it one register per accepted memory transfer.
- Per transfer it emits the register index, a one-hot register-file write select, and an incrementing memory address.
- Sits between decode/execute and the memory stage. Holds stall_req to freeze upstream pipeline stages until the list is exhausted.

Parameters:
- NREG, 8, number of architectural registers; list width and one-hot width.
- RA_W, 3, register index width, log2(NREG).
- AW, 16, memory address width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  begin LM/SM; sampled only in IDLE
- is_load  input  1  1 = LM (memory to registers), 0 = SM (registers to memory); latched with start
- reg_list  input  NREG  register mask; bit [7] selects R0 ... bit [0] selects R7; latched with start
- base_addr  input  AW  first memory address; latched with start
- mem_ready  input  1  memory accepts or completes the current transfer this cycle
- busy  output  1  sequence in progress (RUN or DONE)
- stall_req  output  1  equals busy
- reg_addr  output  RA_W  register index of the current transfer
- reg_sel  output  NREG  one-hot of reg_addr (bit i set means Ri); zero outside RUN
- reg_we  output  1  register-file write strobe (LM only)
- mem_addr  output  AW  current memory address
- mem_rd  output  1  memory read request (LM)
- mem_wr  output  1  memory write request (SM)
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset: synchronous. State goes to IDLE and the internal mask, address and mode registers clear. All outputs are 0. Reset mid-sequence abandons it with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and reg_list!=0: latch mask, base_addr and is_load; go to RUN next cycle.
  - start=1 and reg_list==0: go to DONE. No memory request is issued.
  - start=0: stay in IDLE.
- RUN:
  - Current register is the highest-set bit of the latched mask. Bit [7] maps to index 0 and bit [0] maps to index 7, so the scan runs R0 first, then ascending.
  - reg_addr and reg_sel are combinational from the registered mask.
  - mem_rd=is_load and mem_wr=!is_load are held high throughout RUN. mem_addr is the registered address.
  - reg_we = is_load & mem_ready. Load data is valid in the cycle mem_ready is high.
  - mem_ready=1 (transfer accepted):
    - clear the current bit;
    - mem_addr increments by 1, wrapping modulo 2^AW (0xFFFF to 0x0000);
    - if the cleared mask is 0, go to DONE, otherwise stay in RUN.
  - mem_ready=0: hold everything; outputs stay stable.
- DONE: lasts exactly 1 cycle. done=1, busy=1, no memory or register strobes. Returns to IDLE.
- Latency: first request appears 1 cycle after start. For N set bits with mem_ready tied high, done pulses in cycle N+1 after start, and the next start is accepted in cycle N+2.
- start while busy is ignored. Inputs are not re-sampled during RUN.
- At most one of mem_rd/mem_wr is high; both are 0 outside RUN.

Decomposition:
- Shared package/header holds:
  - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - NREG, RA_W and AW defaults;
  - the bit-to-register mapping constant (index = NREG-1-bit).
- One natural sub-module, lsm_pick. It is combinational: mask in, index plus valid plus next-mask (current bit cleared) out, implementing the fixed scan order. The sequencer instantiates it once on the latched mask.

Test Plan:
- SM, reg_list=8'b1010_0001, base=0x0040, mem_ready=1 -> mem_wr on 3 cycles with (reg_addr, mem_addr) = (0,0x40), (2,0x41), (7,0x42); done in cycle 4; reg_we never high.
- LM, reg_list=8'hFF, base=0x0100, mem_ready=1 -> reg_we 8 cycles, reg_sel = 8'h01, 8'h02, ... 8'h80 in order; addresses 0x100 to 0x107; done in cycle 9.
- LM, reg_list=8'b0000_0100, mem_ready low 3 cycles then high -> reg_addr=5 and mem_addr=base held stable for 4 cycles; single reg_we on the ready cycle; done next cycle.
- start with reg_list=0 -> no mem_rd/mem_wr; done=1 in the following cycle; then IDLE.
- base=0xFFFF, reg_list=8'b1100_0000 -> addresses 0xFFFF then 0x0000; second start during RUN ignored (list not re-latched).
- reset asserted in the 2nd RUN cycle of an 8-register LM -> next cycle all outputs 0, state IDLE, no done; a fresh start then runs normally from its own base.
